// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared state type and segment tables for the scan scheduler
//
// Purpose : FSM state enum, the 16 active-high hex segment patterns (G..A)
//           and the all-off pattern used for anodes and cathodes.
// Ports   : none (package)
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Index n holds the pattern for hex digit n, bit order {G,F,E,D,C,B,A}.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Active-low outputs: all ones means every anode / cathode is off.
  localparam logic [7:0] PAT_BLANK = 8'hFF;

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational hex digit to 7-segment decode
//
// Purpose : map a 4-bit value to its active-high segment pattern.
// Ports   : digit_i [3:0] hex value in
//           seg_o   [6:0] segments {G,F,E,D,C,B,A}, 1 = lit
module hex_seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[digit_i];

endmodule

// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - 8-digit multiplexed 7-segment scan scheduler
//
// Purpose : holds an 8-entry digit buffer, scans it onto 8 common-anode
//           positions with a blanking gap per slot, optional scrolling.
// Ports   : CLK, RST          clock, synchronous active-high reset
//           WR_VALID/WR_READY digit write handshake
//           WR_IDX/WR_DIGIT/WR_DP  physical entry, hex value, decimal point
//           EN_MASK           per-position enable (0 = dark)
//           SCROLL_EN         rotate display every SCROLL_FRAMES frames
//           SSEG_CA/SSEG_AN   active-low cathodes {DP,G..A} / anodes
//           FRAME_DONE        one-cycle pulse at the end of slot 7
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV      = 100000,
  parameter int BLANK_CYC     = 4,
  parameter int SCROLL_FRAMES = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [2:0] WR_IDX,
  input  logic [3:0] WR_DIGIT,
  input  logic       WR_DP,
  input  logic [7:0] EN_MASK,
  input  logic       SCROLL_EN,
  output logic [7:0] SSEG_CA,
  output logic [7:0] SSEG_AN,
  output logic       FRAME_DONE
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(SCROLL_FRAMES - 1);

  scan_state_e   state_q;
  logic [2:0]    clr_idx_q;
  logic [2:0]    ptr_q;
  logic [2:0]    off_q;
  logic [CW-1:0] cyc_q;
  logic [FW-1:0] frm_q;
  logic          frame_done_q;
  logic [7:0]    an_q, an_d;
  logic [7:0]    ca_q, ca_d;

  logic [3:0]    digit_q [8];
  logic [7:0]    dp_q;

  logic [2:0]    sel_idx;
  logic [6:0]    sel_seg;
  logic          wr_fire;
  logic          drive_end;

  // Position ptr shows entry ptr+offset; the 3-bit sum wraps mod 8.
  assign sel_idx = ptr_q + off_q;

  hex_seg_decode u_dec (
    .digit_i (digit_q[sel_idx]),
    .seg_o   (sel_seg)
  );

  // Gated by RST so a write offered during reset never looks accepted.
  assign WR_READY   = (state_q != ST_CLEAR) && !RST;
  assign wr_fire    = WR_VALID && WR_READY;
  assign drive_end  = (state_q == ST_DRIVE) && (cyc_q == DRIVE_LAST);

  assign SSEG_AN    = an_q;
  assign SSEG_CA    = ca_q;
  assign FRAME_DONE = frame_done_q;

  always_comb begin
    an_d = PAT_BLANK;
    ca_d = PAT_BLANK;
    if (state_q == ST_DRIVE && EN_MASK[ptr_q]) begin
      an_d = ~(8'h01 << ptr_q);
      ca_d = ~{dp_q[sel_idx], sel_seg};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= 3'd0;
      ptr_q        <= 3'd0;
      off_q        <= 3'd0;
      cyc_q        <= '0;
      frm_q        <= '0;
      frame_done_q <= 1'b0;
      an_q         <= PAT_BLANK;
      ca_q         <= PAT_BLANK;
    end else begin
      an_q         <= an_d;
      ca_q         <= ca_d;
      frame_done_q <= 1'b0;

      if (wr_fire) begin
        digit_q[WR_IDX] <= WR_DIGIT;
        dp_q[WR_IDX]    <= WR_DP;
      end

      case (state_q)
        ST_CLEAR: begin
          digit_q[clr_idx_q] <= 4'd0;
          dp_q[clr_idx_q]    <= 1'b0;
          clr_idx_q          <= clr_idx_q + 3'd1;
          if (clr_idx_q == 3'd7) begin
            state_q <= ST_BLANK;
            ptr_q   <= 3'd0;
            cyc_q   <= '0;
          end
        end
        ST_BLANK: begin
          if (cyc_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (drive_end) begin
            state_q <= ST_BLANK;
            cyc_q   <= '0;
            ptr_q   <= ptr_q + 3'd1;
            if (ptr_q == 3'd7) begin
              frame_done_q <= 1'b1;
              if (SCROLL_EN) begin
                if (frm_q == FRM_LAST) begin
                  frm_q <= '0;
                  off_q <= off_q + 3'd1;
                end else begin
                  frm_q <= frm_q + FW'(1);
                end
              end
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: state_q <= ST_CLEAR;
      endcase

      // A disabled scroll restarts a full count when it is re-enabled.
      if (!SCROLL_EN) frm_q <= '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - self-checking bench for seg_scan_scheduler
module tb_seg_scan_scheduler;

  localparam int SCAN_DIV      = 8;
  localparam int BLANK_CYC     = 2;
  localparam int SCROLL_FRAMES = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [2:0] WR_IDX = 3'd0;
  logic [3:0] WR_DIGIT = 4'd0;
  logic       WR_DP = 1'b0;
  logic [7:0] EN_MASK = 8'hFF;
  logic       SCROLL_EN = 1'b0;
  logic [7:0] SSEG_CA;
  logic [7:0] SSEG_AN;
  logic       FRAME_DONE;

  seg_scan_scheduler #(
    .SCAN_DIV      (SCAN_DIV),
    .BLANK_CYC     (BLANK_CYC),
    .SCROLL_FRAMES (SCROLL_FRAMES)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_IDX     (WR_IDX),
    .WR_DIGIT   (WR_DIGIT),
    .WR_DP      (WR_DP),
    .EN_MASK    (EN_MASK),
    .SCROLL_EN  (SCROLL_EN),
    .SSEG_CA    (SSEG_CA),
    .SSEG_AN    (SSEG_AN),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'b0111111;  4'h1: seg_of = 7'b0000110;
      4'h2: seg_of = 7'b1011011;  4'h3: seg_of = 7'b1001111;
      4'h4: seg_of = 7'b1100110;  4'h5: seg_of = 7'b1101101;
      4'h6: seg_of = 7'b1111101;  4'h7: seg_of = 7'b0000111;
      4'h8: seg_of = 7'b1111111;  4'h9: seg_of = 7'b1101111;
      4'hA: seg_of = 7'b1110111;  4'hB: seg_of = 7'b1111100;
      4'hC: seg_of = 7'b0111001;  4'hD: seg_of = 7'b1011110;
      4'hE: seg_of = 7'b1111001;  default: seg_of = 7'b1110001;
    endcase
  endfunction

  // Reference model: t counts cycles since the last reset edge; the schedule
  // (clear, slot, phase, frame) is derived arithmetically from t.
  bit         model_valid = 1'b0;
  int         t = 0;
  int         off_m = 0;
  int         fc_m = 0;
  logic [3:0] m_digit [8];
  logic       m_dp [8];
  logic [7:0] exp_an = 8'hFF;
  logic [7:0] exp_ca = 8'hFF;
  logic       exp_fd = 1'b0;

  task automatic tick();
    int  s, slot, ph, e;
    bit  clear, drive;
    @(negedge CLK);
    if (model_valid) begin
      chk("model_an", SSEG_AN, exp_an);
      chk("model_ca", SSEG_CA, exp_ca);
      chk("model_fd", {7'd0, FRAME_DONE}, {7'd0, exp_fd});
      chk("model_ready", {7'd0, WR_READY}, {7'd0, (!RST && t >= 8)});
    end
    if (RST) begin
      exp_an = 8'hFF; exp_ca = 8'hFF; exp_fd = 1'b0;
      t = 0; off_m = 0; fc_m = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      clear = (t < 8);
      s     = clear ? 0 : t - 8;
      slot  = (s / SCAN_DIV) % 8;
      ph    = s % SCAN_DIV;
      drive = !clear && (ph >= BLANK_CYC);
      exp_an = 8'hFF; exp_ca = 8'hFF;
      if (drive && EN_MASK[slot]) begin
        e      = (slot + off_m) % 8;
        exp_an = ~(8'h01 << slot);
        exp_ca = ~{m_dp[e], seg_of(m_digit[e])};
      end
      exp_fd = drive && (slot == 7) && (ph == SCAN_DIV - 1);
      if (clear) begin
        m_digit[t] = 4'd0; m_dp[t] = 1'b0;
      end else if (WR_VALID) begin
        m_digit[WR_IDX] = WR_DIGIT; m_dp[WR_IDX] = WR_DP;
      end
      if (exp_fd && SCROLL_EN) begin
        if (fc_m + 1 == SCROLL_FRAMES) begin
          fc_m = 0; off_m = (off_m + 1) % 8;
        end else begin
          fc_m++;
        end
      end
      if (!SCROLL_EN) fc_m = 0;
      t++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [3:0] d, input logic dp);
    bit ok = 1'b0;
    WR_VALID = 1'b1; WR_IDX = idx; WR_DIGIT = d; WR_DP = dp;
    for (int i = 0; i < 40; i++) begin
      if (WR_READY) begin
        tick(); ok = 1'b1; break;
      end
      tick();
    end
    WR_VALID = 1'b0;
    chk("wr_handshake", {7'd0, ok}, 8'h01);
  endtask

  task automatic wait_an(input logic [7:0] an, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (SSEG_AN === an) begin
        ok = 1'b1; break;
      end
      tick();
    end
  endtask

  task automatic wait_fd(input int count, input int limit, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (FRAME_DONE === 1'b1) begin
        seen++;
        if (seen == count) begin
          ok = 1'b1; break;
        end
      end
    end
  endtask

  typedef struct {
    logic [2:0] idx;
    logic [3:0] digit;
    logic       dp;
    logic [7:0] exp_an;
    logic [7:0] exp_ca;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit ok;
    int bad, k;
    int fd_at[$];

    vecs[0] = '{3'd3, 4'hA, 1'b1, 8'hF7, 8'h08};
    vecs[1] = '{3'd0, 4'h5, 1'b0, 8'hFE, 8'h92};
    vecs[2] = '{3'd5, 4'hF, 1'b1, 8'hDF, 8'h0E};
    vecs[3] = '{3'd7, 4'h8, 1'b0, 8'h7F, 8'h80};
    vecs[4] = '{3'd1, 4'h1, 1'b1, 8'hFD, 8'h79};
    vecs[5] = '{3'd6, 4'hB, 1'b0, 8'hBF, 8'h83};
    vecs[6] = '{3'd2, 4'h2, 1'b0, 8'hFB, 8'hA4};
    vecs[7] = '{3'd4, 4'h7, 1'b1, 8'hEF, 8'h78};
    for (int i = 0; i < 8; i++) begin
      m_digit[i] = 4'd0; m_dp[i] = 1'b0;
    end

    // Reset state and release timing
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_an", SSEG_AN, 8'hFF);
    chk("rst_ca", SSEG_CA, 8'hFF);
    chk("rst_fd", {7'd0, FRAME_DONE}, 8'h00);
    chk("rst_ready", {7'd0, WR_READY}, 8'h00);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (WR_READY !== 1'b0 || SSEG_AN !== 8'hFF) bad++;
      tick();
    end
    chk_int("clear_window", bad, 0);
    k = 8;
    while (SSEG_AN === 8'hFF && k < 40) begin
      tick(); k++;
    end
    chk_int("first_drive_cycle", k, 11);
    chk("first_drive_an", SSEG_AN, 8'hFE);
    chk("first_drive_ca", SSEG_CA, 8'hC0);

    // Table: write each entry, then check its position's anode and cathodes
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].idx, vecs[i].digit, vecs[i].dp);
      tick(); tick();
      wait_an(vecs[i].exp_an, 80, ok);
      chk("vec_an_seen", {7'd0, ok}, 8'h01);
      chk("vec_ca", SSEG_CA, vecs[i].exp_ca);
    end

    // Write to the entry being driven: CA changes 2 cycles after handshake
    wait_an(8'hFB, 80, ok);
    chk("live_wr_sync", {7'd0, ok}, 8'h01);
    wait_an(8'hF7, 80, ok);
    chk("live_wr_slot3", {7'd0, ok}, 8'h01);
    chk("live_wr_ready", {7'd0, WR_READY}, 8'h01);
    WR_VALID = 1'b1; WR_IDX = 3'd3; WR_DIGIT = 4'h5; WR_DP = 1'b0;
    tick();
    WR_VALID = 1'b0;
    chk("live_wr_an1", SSEG_AN, 8'hF7);
    chk("live_wr_ca1", SSEG_CA, 8'h08);
    tick();
    chk("live_wr_an2", SSEG_AN, 8'hF7);
    chk("live_wr_ca2", SSEG_CA, 8'h92);

    // Partial enable mask: upper positions dark, frame period unchanged
    EN_MASK = 8'h0F;
    bad = 0;
    for (int i = 0; i < 140; i++) begin
      tick();
      if (SSEG_AN[7:4] !== 4'hF) bad++;
      if (SSEG_AN === 8'hFF && SSEG_CA !== 8'hFF) bad++;
      if (FRAME_DONE === 1'b1) fd_at.push_back(i);
    end
    chk_int("mask_dark", bad, 0);
    chk_int("fd_pulses_ge2", (fd_at.size() >= 2) ? 1 : 0, 1);
    if (fd_at.size() >= 2) chk_int("fd_period", fd_at[1] - fd_at[0], 64);
    EN_MASK = 8'hFF;

    // Reset mid-DRIVE of slot 5 with a write pending
    wait_an(8'hDF, 80, ok);
    chk("rst_mid_slot5", {7'd0, ok}, 8'h01);
    RST = 1'b1;
    WR_VALID = 1'b1; WR_IDX = 3'd5; WR_DIGIT = 4'h9; WR_DP = 1'b1;
    tick();
    RST = 1'b0; WR_VALID = 1'b0;
    chk("rst_mid_ready", {7'd0, WR_READY}, 8'h00);
    chk("rst_mid_an", SSEG_AN, 8'hFF);
    chk("rst_mid_ca", SSEG_CA, 8'hFF);
    for (int p = 0; p < 8; p++) begin
      wait_an(~(8'h01 << p), 80, ok);
      chk("post_clear_seen", {7'd0, ok}, 8'h01);
      chk("post_clear_ca", SSEG_CA, 8'hC0);
    end

    // Scrolling: entry 0 = 1, offset steps every 2 frames, wraps after 16
    RST = 1'b1; SCROLL_EN = 1'b1;
    tick();
    RST = 1'b0;
    do_write(3'd0, 4'h1, 1'b0);
    wait_fd(2, 300, ok);
    chk("scroll_fd2", {7'd0, ok}, 8'h01);
    tick();
    wait_an(8'h7F, 80, ok);
    chk("scroll_pos7_seen", {7'd0, ok}, 8'h01);
    chk("scroll_pos7_ca", SSEG_CA, 8'hF9);
    wait_an(8'hFE, 80, ok);
    chk("scroll_pos0_seen", {7'd0, ok}, 8'h01);
    chk("scroll_pos0_ca", SSEG_CA, 8'hC0);
    wait_fd(14, 1200, ok);
    chk("scroll_fd16", {7'd0, ok}, 8'h01);
    tick();
    wait_an(8'hFE, 80, ok);
    chk("scroll_wrap_seen", {7'd0, ok}, 8'h01);
    chk("scroll_wrap_ca", SSEG_CA, 8'hF9);

    // Randomized traffic against the reference model
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      WR_VALID = ($urandom_range(0, 9) < 3);
      WR_IDX   = 3'($urandom_range(0, 7));
      WR_DIGIT = 4'($urandom_range(0, 15));
      WR_DP    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) EN_MASK = 8'($urandom);
      if ($urandom_range(0, 199) == 0) SCROLL_EN = ~SCROLL_EN;
      RST = ($urandom_range(0, 799) == 0);
      tick();
    end
    RST = 1'b0; WR_VALID = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000: CLK cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_CYC, default 4: leading cycles of each slot with all anodes off (anti-ghosting); BLANK_CYC < SCAN_DIV.
REQ-003 The block SHALL have parameter SCROLL_FRAMES, default 250: complete 8-slot frames per scroll step (2 s at defaults).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port WR_VALID, input, 1 bit: digit-write request.
REQ-007 The block SHALL have port WR_READY, output, 1 bit: write accepted when WR_VALID && WR_READY.
REQ-008 The block SHALL have port WR_IDX, input, 3 bits: physical buffer entry to write.
REQ-009 The block SHALL have port WR_DIGIT, input, 4 bits: hex value to store.
REQ-010 The block SHALL have port WR_DP, input, 1 bit: decimal point for that entry, 1 = lit.
REQ-011 The block SHALL have port EN_MASK, input, 8 bits: per-anode-position enable, 0 = position stays dark.
REQ-012 The block SHALL have port SCROLL_EN, input, 1 bit: 1 = rotate the display every SCROLL_FRAMES frames.
REQ-013 The block SHALL have port SSEG_CA, output, 8 bits: active-low cathodes {DP,G,F,E,D,C,B,A}.
REQ-014 The block SHALL have port SSEG_AN, output, 8 bits: active-low anodes, bit p = position p.
REQ-015 The block SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse at the end of slot 7.

Function
REQ-016 The FSM SHALL have states CLEAR, BLANK and DRIVE, plus a 3-bit slot pointer, 3-bit scroll offset, slot cycle counter and frame counter.
REQ-017 CLEAR SHALL last exactly 8 cycles and zero buffer entries 0..7 (digit 0, DP 0), one per cycle; WR_READY=0 throughout, then the FSM enters BLANK with pointer 0.
REQ-018 BLANK SHALL last BLANK_CYC cycles and DRIVE SHALL last SCAN_DIV-BLANK_CYC cycles; DRIVE then goes to BLANK with pointer+1 mod 8 (7 wraps to 0).
REQ-019 During DRIVE, SSEG_AN SHALL be all ones except bit p=pointer, which is 0 only if EN_MASK[p]=1; in CLEAR and BLANK, SSEG_AN SHALL be 8'hFF.
REQ-020 Position p SHALL display buffer entry (p+offset) mod 8, with SSEG_CA = ~{dp, seg[6:0]}; SSEG_CA SHALL be 8'hFF whenever SSEG_AN is 8'hFF.
REQ-021 SSEG_AN and SSEG_CA SHALL be registered, reflecting the state, pointer and buffer of the previous cycle (1-cycle latency).
REQ-022 WR_READY SHALL be 1 in BLANK and DRIVE; an accepted write SHALL update the entry at the next edge, with SSEG_CA reflecting it one cycle later if that entry is being driven.
REQ-023 FRAME_DONE SHALL pulse for 1 cycle, coincident with the DRIVE->BLANK transition out of pointer 7.
REQ-024 At a frame end with SCROLL_EN=1, the frame counter SHALL increment; on reaching SCROLL_FRAMES-1 it SHALL clear and offset SHALL increment mod 8 (7 wraps to 0).
REQ-025 When SCROLL_EN=0, the frame counter SHALL be held at 0 and the offset held; re-enabling starts a full SCROLL_FRAMES count.
REQ-026 A write and a scroll step in the same cycle SHALL both take effect, since writes use physical indices and are unaffected by the offset.
REQ-027 EN_MASK changes SHALL take effect on the next registered output; no slot timing changes.

Reset
REQ-028 RST=1 at any edge, including mid-frame or mid-write, SHALL force: state CLEAR with index 0, pointer 0, offset 0, all counters 0, WR_READY 0, FRAME_DONE 0, SSEG_AN 8'hFF, SSEG_CA 8'hFF.
REQ-029 A write presented while RST=1 SHALL be dropped.
REQ-030 CLEAR SHALL start on the first cycle after RST falls.

Structure
REQ-031 Package seg_scan_pkg SHALL hold the state enum, the 16 hex segment patterns (active-high, G..A) and the blank pattern constant.
REQ-032 Sub-module hex_seg_decode SHALL hold the combinational 4-bit -> 7-bit active-high segment decode, instantiated once on the selected buffer entry.

Verification
REQ-033 The bench SHALL use SCAN_DIV=8, BLANK_CYC=2 and SCROLL_FRAMES=2 unless a scenario states otherwise.
REQ-034 Reset release: 8 cycles of WR_READY=0 with AN=FF, then AN=8'hFE appears at cycle 8+2+1 after release, with CA=8'hC0 (digit 0, DP off).
REQ-035 Write idx3=0xA, DP=1: slot 3 drive shows AN=8'hF7, CA=8'h08.
REQ-036 EN_MASK=8'h0F: slots 4..7 keep AN=FF with CA=FF; FRAME_DONE pulses every 64 cycles.
REQ-037 SCROLL_EN=1, entry0=1, rest 0: after 2 frames offset=1, and position 7 shows digit 1 (CA=8'hF9); after 16 frames offset wraps to 0.
REQ-038 RST pulsed in mid-DRIVE of slot 5 with a write pending: next cycle WR_READY=0, then AN=FF and the buffer reads all zeros after CLEAR.
REQ-039 A write to the currently driven entry SHALL change CA exactly 2 cycles after the handshake, with no AN glitch.
